// File: rtl/core_state_dumper_if.sv
// Word-stream interface carrying one dump beat per valid&ready handshake.
//   valid : beat present on data/kind/idx/last
//   ready : sink accepts the beat when valid & ready
//   data  : beat payload
//   kind  : 0=header 1=register 2=memory
//   idx   : register/memory index (0 on header)
//   last  : high on the final memory beat only
interface core_state_dumper_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [1:0]        kind;
  logic [4:0]        idx;
  logic              last;

  modport master (output valid, data, kind, idx, last, input ready);
  modport slave  (input valid, data, kind, idx, last, output ready);
endinterface

// File: rtl/core_state_dumper.sv
// Snapshots the core's register file and data memory when the core halts and
// streams them out as: header, reg0..reg31, mem0..mem31 (65 beats per dump).
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   halt       : core in FIM state (level)
//   reg_flat   : reg i at bits [i*DATA_W +: DATA_W]
//   mem_flat   : mem i at bits [i*DATA_W +: DATA_W]
//   dump       : beat stream (valid/ready/data/kind/idx/last)
//   busy       : dump in progress (header through memory beats)
//   dump_done  : one-cycle pulse after the last beat is accepted
//   dump_count : completed dumps, wraps 255 -> 0
module core_state_dumper #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_MEM  = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [15:0] HDR_TAG  = 16'hD0D0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_flat,
  input  logic [NUM_MEM*DATA_W-1:0]    mem_flat,
  core_state_dumper_if.master          dump,
  output logic                         busy,
  output logic                         dump_done,
  output logic [7:0]                   dump_count
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [IDX_W-1:0]  REG_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]  MEM_LAST = IDX_W'(NUM_MEM - 1);

  localparam logic [KIND_W-1:0] KIND_HDR = KIND_W'(0);
  localparam logic [KIND_W-1:0] KIND_REG = KIND_W'(1);
  localparam logic [KIND_W-1:0] KIND_MEM = KIND_W'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_REGS = 3'd2,
    S_MEMS = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_n;

  logic                halt_q;
  logic [DATA_W-1:0]   snap_reg [NUM_REGS];
  logic [DATA_W-1:0]   snap_mem [NUM_MEM];

  logic                valid_q, valid_n;
  logic [DATA_W-1:0]   data_q,  data_n;
  logic [KIND_W-1:0]   kind_q,  kind_n;
  logic [IDX_W-1:0]    idx_q,   idx_n;
  logic                last_q,  last_n;
  logic                busy_q,  busy_n;
  logic                done_q,  done_n;
  logic [CNT_W-1:0]    count_q, count_n;

  logic                capture;
  logic                fire;
  logic [IDX_W-1:0]    idx_inc;

  // Outputs are all registered; the interface just exposes the flops.
  assign dump.valid = valid_q;
  assign dump.data  = data_q;
  assign dump.kind  = kind_q;
  assign dump.idx   = idx_q;
  assign dump.last  = last_q;
  assign busy       = busy_q;
  assign dump_done  = done_q;
  assign dump_count = count_q;

  // State, halt edge history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      kind_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_n;
      halt_q  <= halt;
      valid_q <= valid_n;
      data_q  <= data_n;
      kind_q  <= kind_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      count_q <= count_n;
    end
  end

  // Snapshot storage, loaded only on the triggering halt edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) snap_reg[i] <= '0;
      for (int i = 0; i < int'(NUM_MEM); i++)  snap_mem[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(NUM_REGS); i++) snap_reg[i] <= reg_flat[i*DATA_W +: DATA_W];
      for (int i = 0; i < int'(NUM_MEM); i++)  snap_mem[i] <= mem_flat[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic; holding is the default so a stalled
  // beat (valid & ~ready) keeps every output stable.
  always_comb begin
    state_n = state;
    valid_n = valid_q;
    data_n  = data_q;
    kind_n  = kind_q;
    idx_n   = idx_q;
    last_n  = last_q;
    done_n  = 1'b0;
    count_n = count_q;
    capture = 1'b0;
    fire    = valid_q & dump.ready;
    idx_inc = idx_q + IDX_W'(1);

    unique case (state)
      S_IDLE: begin
        if (halt && !halt_q) begin
          capture = 1'b1;
          state_n = S_HDR;
          valid_n = 1'b1;
          data_n  = DATA_W'({HDR_TAG, 8'h00, count_q});
          kind_n  = KIND_HDR;
          idx_n   = '0;
          last_n  = 1'b0;
        end
      end
      S_HDR: begin
        if (fire) begin
          state_n = S_REGS;
          data_n  = snap_reg[0];
          kind_n  = KIND_REG;
          idx_n   = '0;
        end
      end
      S_REGS: begin
        if (fire) begin
          if (idx_q == REG_LAST) begin
            state_n = S_MEMS;
            data_n  = snap_mem[0];
            kind_n  = KIND_MEM;
            idx_n   = '0;
            last_n  = 1'b0;
          end else begin
            idx_n  = idx_inc;
            data_n = snap_reg[idx_inc];
          end
        end
      end
      S_MEMS: begin
        if (fire) begin
          if (idx_q == MEM_LAST) begin
            // Final beat taken: drop the stream and report completion.
            state_n = S_DONE;
            valid_n = 1'b0;
            data_n  = '0;
            kind_n  = '0;
            idx_n   = '0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            count_n = count_q + CNT_W'(1);
          end else begin
            idx_n  = idx_inc;
            data_n = snap_mem[idx_inc];
            last_n = (idx_inc == MEM_LAST);
          end
        end
      end
      S_DONE: begin
        // Wait for halt to drop so one halt period yields exactly one dump.
        if (!halt) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_HDR) || (state_n == S_REGS) || (state_n == S_MEMS);
  end

endmodule
